// File: rtl/rs_pkg.sv
// Shared reservation-station definitions: opcodes, the "no tag" encoding and
// the mapping from entry index to the CDB tag that entry owns.
package rs_pkg;

  localparam int TAG_NONE = 0;

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_SUB = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b111001;
  localparam logic [5:0] OP_JMP = 6'b011010;

  function automatic int entry_tag(input int base, input int i);
    return base + i;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Relative-age tracker: row i holds a bit for every entry allocated before i.
// The grant is the requesting entry that has no older requester.
module rs_age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] free,
  input  logic [N-1:0] valid,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  logic [N-1:0] age_q [N];
  logic [N-1:0] age_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      // A freed entry must drop out of every row, or a later reuse of its
      // slot would look older than entries that really precede it.
      age_d[i] = age_q[i] & ~free;
      if (alloc[i]) begin
        age_d[i] = valid & ~free;
      end
      if (flush) begin
        age_d[i] = '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      grant[i] = req[i] & ~(|(req & age_q[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

// File: rtl/rs_alu_param.sv
// Integer/branch reservation station: holds issued ops, snoops the CDB for
// missing operands and offers the oldest ready entry to the ALU.
module rs_alu_param
  import rs_pkg::*;
#(
  parameter int NUM_RS   = 4,
  parameter int XLEN     = 64,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 1,
  parameter int ROB_W    = 2,
  parameter int OPC_W    = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  output logic [TAG_W-1:0]             issue_tag,
  input  logic [OPC_W-1:0]             issue_opcode,
  input  logic [TAG_W-1:0]             issue_tag1,
  input  logic [TAG_W-1:0]             issue_tag2,
  input  logic [XLEN-1:0]              issue_op1,
  input  logic [XLEN-1:0]              issue_op2,
  input  logic [XLEN-1:0]              issue_pc,
  input  logic [XLEN-1:0]              issue_off,
  input  logic [ROB_W-1:0]             issue_rob,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [XLEN-1:0]              cdb_data,
  output logic                         fu_valid,
  input  logic                         fu_ready,
  output logic [XLEN-1:0]              fu_a,
  output logic [XLEN-1:0]              fu_b,
  output logic [XLEN-1:0]              fu_pc,
  output logic [XLEN-1:0]              fu_off,
  output logic [OPC_W-1:0]             fu_opcode,
  output logic [TAG_W-1:0]             fu_tag,
  output logic [ROB_W-1:0]             fu_rob,
  output logic [$clog2(NUM_RS+1)-1:0]  occupancy
);

  localparam int IDX_W = $clog2(NUM_RS);
  localparam int OCC_W = $clog2(NUM_RS+1);

  // Handshake: an offer (fu_valid) transfers on any cycle where fu_ready is
  // also high; once raised, the offer is held unchanged until it transfers.

  logic [NUM_RS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]  tag1_q [NUM_RS];
  logic [TAG_W-1:0]  tag1_d [NUM_RS];
  logic [TAG_W-1:0]  tag2_q [NUM_RS];
  logic [TAG_W-1:0]  tag2_d [NUM_RS];
  logic [XLEN-1:0]   op1_q  [NUM_RS];
  logic [XLEN-1:0]   op1_d  [NUM_RS];
  logic [XLEN-1:0]   op2_q  [NUM_RS];
  logic [XLEN-1:0]   op2_d  [NUM_RS];
  logic [XLEN-1:0]   pc_q   [NUM_RS];
  logic [XLEN-1:0]   pc_d   [NUM_RS];
  logic [XLEN-1:0]   off_q  [NUM_RS];
  logic [XLEN-1:0]   off_d  [NUM_RS];
  logic [OPC_W-1:0]  opc_q  [NUM_RS];
  logic [OPC_W-1:0]  opc_d  [NUM_RS];
  logic [ROB_W-1:0]  rob_q  [NUM_RS];
  logic [ROB_W-1:0]  rob_d  [NUM_RS];
  logic              lock_q, lock_d;
  logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic [NUM_RS-1:0] ready, grant, alloc_oh, free_oh;
  logic [IDX_W-1:0]  free_idx, sel_idx, cur_idx;
  logic              do_issue, accept, cdb_live;

  assign cdb_live = cdb_valid && (cdb_tag != TAG_W'(TAG_NONE));

  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      ready[i] = valid_q[i] && (tag1_q[i] == TAG_W'(TAG_NONE)) &&
                 (tag2_q[i] == TAG_W'(TAG_NONE));
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = NUM_RS-1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
    sel_idx = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (grant[i]) sel_idx = IDX_W'(i);
    end
  end

  assign issue_ready = ~(&valid_q);
  assign issue_tag   = issue_ready ? TAG_W'(entry_tag(TAG_BASE, int'(free_idx))) : '0;
  assign fu_valid    = lock_q | (|ready);
  assign cur_idx     = lock_q ? lock_idx_q : sel_idx;
  assign do_issue    = issue_valid && issue_ready && !flush;
  assign accept      = fu_valid && fu_ready && !flush;
  assign alloc_oh    = do_issue ? (NUM_RS'(1) << free_idx) : '0;
  assign free_oh     = accept ? (NUM_RS'(1) << cur_idx) : '0;
  assign occupancy   = occ_q;

  always_comb begin
    fu_a      = '0;
    fu_b      = '0;
    fu_pc     = '0;
    fu_off    = '0;
    fu_opcode = '0;
    fu_tag    = '0;
    fu_rob    = '0;
    if (fu_valid) begin
      fu_a      = op1_q[cur_idx];
      fu_b      = op2_q[cur_idx];
      fu_pc     = pc_q[cur_idx];
      fu_off    = off_q[cur_idx];
      fu_opcode = opc_q[cur_idx];
      fu_tag    = TAG_W'(entry_tag(TAG_BASE, int'(cur_idx)));
      fu_rob    = rob_q[cur_idx];
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    pc_d    = pc_q;
    off_d   = off_q;
    opc_d   = opc_q;
    rob_d   = rob_q;
    for (int i = 0; i < NUM_RS; i++) begin
      if (cdb_live && valid_q[i] && (tag1_q[i] == cdb_tag)) begin
        op1_d[i]  = cdb_data;
        tag1_d[i] = '0;
      end
      if (cdb_live && valid_q[i] && (tag2_q[i] == cdb_tag)) begin
        op2_d[i]  = cdb_data;
        tag2_d[i] = '0;
      end
    end
    if (accept) begin
      valid_d[cur_idx] = 1'b0;
    end
    if (do_issue) begin
      valid_d[free_idx] = 1'b1;
      pc_d[free_idx]    = issue_pc;
      off_d[free_idx]   = issue_off;
      opc_d[free_idx]   = issue_opcode;
      rob_d[free_idx]   = issue_rob;
      // A producer broadcasting in the issue cycle would otherwise be missed.
      if (cdb_live && (issue_tag1 == cdb_tag)) begin
        op1_d[free_idx]  = cdb_data;
        tag1_d[free_idx] = '0;
      end else begin
        op1_d[free_idx]  = issue_op1;
        tag1_d[free_idx] = issue_tag1;
      end
      if (cdb_live && (issue_tag2 == cdb_tag)) begin
        op2_d[free_idx]  = cdb_data;
        tag2_d[free_idx] = '0;
      end else begin
        op2_d[free_idx]  = issue_op2;
        tag2_d[free_idx] = issue_tag2;
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (flush || accept) begin
      lock_d = 1'b0;
    end else if (fu_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = cur_idx;
    end
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(do_issue) - OCC_W'(accept);
    end
  end

  rs_age_matrix #(.N(NUM_RS)) u_age (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .alloc (alloc_oh),
    .free  (free_oh),
    .valid (valid_q),
    .req   (ready),
    .grant (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      occ_q      <= '0;
      for (int i = 0; i < NUM_RS; i++) begin
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        op1_q[i]  <= '0;
        op2_q[i]  <= '0;
        pc_q[i]   <= '0;
        off_q[i]  <= '0;
        opc_q[i]  <= '0;
        rob_q[i]  <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      occ_q      <= occ_d;
      for (int i = 0; i < NUM_RS; i++) begin
        tag1_q[i] <= tag1_d[i];
        tag2_q[i] <= tag2_d[i];
        op1_q[i]  <= op1_d[i];
        op2_q[i]  <= op2_d[i];
        pc_q[i]   <= pc_d[i];
        off_q[i]  <= off_d[i];
        opc_q[i]  <= opc_d[i];
        rob_q[i]  <= rob_d[i];
      end
    end
  end

endmodule
